gray_ptr_sync: RTL and testbench

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

---
 rtl/gray_ptr_sync.sv | 118 +++++++++++
 tb/tb_gray_ptr_sync.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// gray_ptr_sync : multi-flop Gray pointer synchronizer with binary decode,
//                 step/wrap pulses and wrap counter. Optional transition
//                 checker (err_o) compiled in with GRAY_SYNC_ERRCHK_EN.
// Revision 1.0
// ============================================================================
module gray_ptr_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] gray_i,
   input  logic             clr_err_i,
   output logic [WIDTH-1:0] gray_sync_o,
   output logic [WIDTH-1:0] bin_o,
   output logic             step_o,
   output logic             wrap_o,
   output logic [7:0]       wrap_cnt_o,
   output logic             err_o
);

   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_MAX = '1;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] delta;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic [7:0]       wrap_cnt_q, wrap_cnt_d;

   always_comb begin
      sync_d[0] = gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   // bin_q is the previous binary value (bin_prev) at the moment bin_d is
   // about to be captured, so the delta is taken against it directly.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
      end
      delta      = bin_d - bin_q;
      step_d     = (delta == C_ONE);
      wrap_d     = step_d && (bin_q == C_MAX);
      wrap_cnt_d = wrap_cnt_q + {7'b0, wrap_d};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bin_q      <= '0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         bin_q      <= bin_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

`ifdef GRAY_SYNC_ERRCHK_EN
   logic illegal;
   logic err_q, err_d;

   // A fresh illegal transition wins over a simultaneous clear.
   always_comb begin
      illegal = (delta != '0) && (delta != C_ONE);
      err_d   = err_q;
      if (clr_err_i) begin
         err_d = 1'b0;
      end
      if (illegal) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = clr_err_i;
   assign err_o          = 1'b0;
`endif

   assign gray_sync_o = sync_q[SYNC_STAGES-1];
   assign bin_o       = bin_q;
   assign step_o      = step_q;
   assign wrap_o      = wrap_q;
   assign wrap_cnt_o  = wrap_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
`default_nettype none
// Testbench for gray_ptr_sync: scoreboard of per-edge expected outputs plus
// scenario tasks with inline checks.
module tb_gray_ptr_sync;

   localparam int W = 4;
   localparam int S = 2;
`ifdef GRAY_SYNC_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [W-1:0] gray_i;
   logic         clr_err_i;
   logic [W-1:0] gray_sync_o;
   logic [W-1:0] bin_o;
   logic         step_o;
   logic         wrap_o;
   logic [7:0]   wrap_cnt_o;
   logic         err_o;

   gray_ptr_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .gray_i      (gray_i),
      .clr_err_i   (clr_err_i),
      .gray_sync_o (gray_sync_o),
      .bin_o       (bin_o),
      .step_o      (step_o),
      .wrap_o      (wrap_o),
      .wrap_cnt_o  (wrap_cnt_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [W-1:0] gs;
      logic [W-1:0] bin;
      logic         step;
      logic         wrap;
      logic [7:0]   cnt;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state
   logic [W-1:0] hist [S];
   logic [W-1:0] m_bin;
   logic         m_step, m_wrap, m_err;
   logic [7:0]   m_cnt;

   function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = '0;
      for (int i = 0; i < W; i++) b = b ^ (g >> i);
      return b;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < S; i++) hist[i] = '0;
      m_bin = '0; m_step = 1'b0; m_wrap = 1'b0; m_err = 1'b0; m_cnt = '0;
      sb.delete();
   endtask

   task automatic apply_reset();
      rst_i     = 1'b0;
      gray_i    = '0;
      clr_err_i = 1'b0;
      reset_model();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   // Called just after a negedge: predicts the outputs after the next posedge.
   task automatic drive(input logic [W-1:0] g, input logic c);
      exp_t         e;
      logic [W-1:0] nb, d;
      logic         illegal;
      nb      = g2b(hist[S-1]);
      d       = nb - m_bin;
      m_step  = (d == W'(1));
      m_wrap  = m_step && (m_bin == {W{1'b1}});
      m_cnt   = m_cnt + (m_wrap ? 8'd1 : 8'd0);
      illegal = (d > W'(1));
      m_err   = ERRCHK && ((m_err && !c) || illegal);
      e.gs    = hist[S-2];
      e.bin   = nb;
      e.step  = m_step;
      e.wrap  = m_wrap;
      e.cnt   = m_cnt;
      e.err   = m_err;
      m_bin   = nb;
      for (int i = S-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = g;
      sb.push_back(e);
      gray_i    = g;
      clr_err_i = c;
      @(negedge clk_i);
   endtask

   always @(posedge clk_i) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if ({gray_sync_o, bin_o, step_o, wrap_o, wrap_cnt_o, err_o} !== e) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got/exp gs=%h/%h bin=%0d/%0d step=%b/%b wrap=%b/%b cnt=%0d/%0d err=%b/%b",
                     $time, gray_sync_o, e.gs, bin_o, e.bin, step_o, e.step, wrap_o, e.wrap,
                     wrap_cnt_o, e.cnt, err_o, e.err);
         end
      end
   end

   task automatic test_reset();
      rst_i = 1'b0; gray_i = 4'b0110; clr_err_i = 1'b0;
      reset_model();
      #2;
      vectors++;
      if ({gray_sync_o, bin_o, step_o, wrap_o, wrap_cnt_o, err_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_state got gs=%h bin=%h step=%b wrap=%b cnt=%h err=%b required all 0",
                  gray_sync_o, bin_o, step_o, wrap_o, wrap_cnt_o, err_o);
      end
      apply_reset();
   endtask

   task automatic test_single_step();
      apply_reset();
      drive(4'b0000, 1'b0);
      drive(4'b0001, 1'b0);
      drive(4'b0001, 1'b0);
      vectors++;
      if (bin_o !== 4'd0 || step_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_step_early got bin=%0d step=%b required bin=0 step=0", bin_o, step_o);
      end
      drive(4'b0001, 1'b0);
      vectors++;
      if (bin_o !== 4'd1 || step_o !== 1'b1) begin
         miscompares++;
         $display("FAIL single_step got bin=%0d step=%b required bin=1 step=1", bin_o, step_o);
      end
      drive(4'b0001, 1'b0);
      vectors++;
      if (step_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_step_pulse got step=%b required 0", step_o);
      end
   endtask

   task automatic test_full_sequence();
      int steps = 0;
      int wraps = 0;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(b2g(4'(i)), 1'b0);
         steps += int'(step_o);
         wraps += int'(wrap_o);
      end
      for (int i = 0; i < 4; i++) begin
         drive(4'b0000, 1'b0);
         steps += int'(step_o);
         wraps += int'(wrap_o);
      end
      vectors++;
      if (steps != 16 || wraps != 1 || wrap_cnt_o !== 8'd1) begin
         miscompares++;
         $display("FAIL full_sequence got steps=%0d wraps=%0d cnt=%0d required 16/1/1",
                  steps, wraps, wrap_cnt_o);
      end
   endtask

   task automatic test_illegal_jump();
      apply_reset();
      drive(4'b0000, 1'b0);
      repeat (3) drive(4'b0011, 1'b0);
      vectors++;
      if (bin_o !== 4'd2 || step_o !== 1'b0 || wrap_o !== 1'b0 || err_o !== ERRCHK) begin
         miscompares++;
         $display("FAIL illegal_jump got bin=%0d step=%b wrap=%b err=%b required bin=2 step=0 wrap=0 err=%b",
                  bin_o, step_o, wrap_o, err_o, ERRCHK);
      end
      repeat (3) drive(4'b0011, 1'b0);
      vectors++;
      if (err_o !== ERRCHK) begin
         miscompares++;
         $display("FAIL err_hold got err=%b required %b", err_o, ERRCHK);
      end
      drive(4'b0011, 1'b1);
      vectors++;
      if (err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear got err=%b required 0", err_o);
      end
      drive(4'b0011, 1'b0);
   endtask

   task automatic test_clr_coincident();
      repeat (3) drive(b2g(4'd5), 1'b0);
      vectors++;
      if (bin_o !== 4'd5 || err_o !== ERRCHK) begin
         miscompares++;
         $display("FAIL err_set2 got bin=%0d err=%b required bin=5 err=%b", bin_o, err_o, ERRCHK);
      end
      drive(b2g(4'd9), 1'b0);
      drive(b2g(4'd9), 1'b0);
      drive(b2g(4'd9), 1'b1);
      vectors++;
      if (bin_o !== 4'd9 || err_o !== ERRCHK) begin
         miscompares++;
         $display("FAIL clr_coincident got bin=%0d err=%b required bin=9 err=%b", bin_o, err_o, ERRCHK);
      end
      drive(b2g(4'd9), 1'b0);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 8; i++) drive(b2g(4'(i)), 1'b0);
      drive(b2g(4'd7), 1'b0);
      drive(b2g(4'd7), 1'b0);
      vectors++;
      if (bin_o !== 4'd7 || step_o !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset got bin=%0d step=%b required bin=7 step=1", bin_o, step_o);
      end
      #3;
      rst_i = 1'b0;
      reset_model();
      #1;
      vectors++;
      if ({gray_sync_o, bin_o, step_o, wrap_o, wrap_cnt_o, err_o} !== '0) begin
         miscompares++;
         $display("FAIL async_reset got gs=%h bin=%h step=%b wrap=%b cnt=%h err=%b required all 0",
                  gray_sync_o, bin_o, step_o, wrap_o, wrap_cnt_o, err_o);
      end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) drive(4'b0100, 1'b0);
      vectors++;
      if (bin_o !== 4'd7 || step_o !== 1'b0 || err_o !== ERRCHK) begin
         miscompares++;
         $display("FAIL post_reset got bin=%0d step=%b err=%b required bin=7 step=0 err=%b",
                  bin_o, step_o, err_o, ERRCHK);
      end
      drive(4'b0100, 1'b0);
   endtask

   task automatic test_wrap_256();
      apply_reset();
      drive(4'b0000, 1'b0);
      for (int w = 0; w < 256; w++) begin
         for (int i = 1; i <= 16; i++) drive(b2g(4'(i)), 1'b0);
      end
      repeat (3) drive(4'b0000, 1'b0);
      vectors++;
      if (wrap_cnt_o !== 8'd0) begin
         miscompares++;
         $display("FAIL wrap_256 got cnt=%0d required 0", wrap_cnt_o);
      end
      for (int i = 1; i <= 16; i++) drive(b2g(4'(i)), 1'b0);
      repeat (3) drive(4'b0000, 1'b0);
      vectors++;
      if (wrap_cnt_o !== 8'd1) begin
         miscompares++;
         $display("FAIL wrap_257 got cnt=%0d required 1", wrap_cnt_o);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_step();
      test_full_sequence();
      test_illegal_jump();
      test_clr_coincident();
      test_reset_mid();
      test_wrap_256();
      @(negedge clk_i);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
